// File: rtl/sid_bus_frontend_if.sv
// Host-bus pad/output bundle for the SID bus front end.
// The sid package carries the bus_i_t bundle that feeds sid_control.
`timescale 1ns/1ps
package sid;
   typedef struct packed {
      logic       phi2;
      logic       r_w_n;
      logic [4:0] addr;
      logic [7:0] data;
      logic       res;
   } bus_i_t;
endpackage

interface sid_bus_frontend_if;
   import sid::*;
   logic       phi2_pad;
   logic       r_w_n_pad;
   logic       cs_n_pad;
   logic [8:0] addr_pad;
   logic [7:0] data_pad;
   bus_i_t     bus_o;
   logic [1:0] cs;
   logic       data_oe;
   logic       bus_idle;

   modport master (
      output phi2_pad, r_w_n_pad, cs_n_pad, addr_pad, data_pad,
      input  bus_o, cs, data_oe, bus_idle
   );
   modport slave (
      input  phi2_pad, r_w_n_pad, cs_n_pad, addr_pad, data_pad,
      output bus_o, cs, data_oe, bus_idle
   );
endinterface

// File: rtl/sid_bus_frontend.sv
// MOS6510 host-bus front end: pin sync, PHI2 filter/tracker, SID chip selects.
// Optional bus watchdog (bus_idle, cs gating) enabled by SID_BUS_WATCHDOG_EN.
`timescale 1ns/1ps
module sid_bus_frontend #(
   parameter int SYNC_STAGES = 2,
   parameter int PHI2_FILT   = 3,
   parameter int ADDR_DELAY  = 4,
   parameter int SID2_A8     = 0,
   parameter int WDOG_CYCLES = 96
) (
   input logic             clk,
   input logic             res_n,
   sid_bus_frontend_if.slave bus
);
   import sid::*;

   typedef enum logic [1:0] {
      S_LOW,
      S_SETUP,
      S_HIGH
   } state_e;

   localparam logic [1:0] FILT_M1 = 2'(PHI2_FILT - 1);
   localparam logic [3:0] DLY_M1  = 4'(ADDR_DELAY - 1);

   logic [19:0] sync_q [SYNC_STAGES];
   logic [19:0] pad_w;
   logic [19:0] pad_s;

   assign pad_w = {bus.phi2_pad, bus.r_w_n_pad, bus.cs_n_pad,
                   bus.addr_pad, bus.data_pad};

   always_ff @(posedge clk) begin
      sync_q[0] <= pad_w;
      for (int i = 1; i < SYNC_STAGES; i++)
         sync_q[i] <= sync_q[i-1];
   end

   assign pad_s = sync_q[SYNC_STAGES-1];

   logic       phi2_s;
   logic       rw_s;
   logic       csn_s;
   logic [8:0] addr_s;
   logic [7:0] data_s;
   logic       sel2;
   logic [1:0] cs_new;
   logic       unused_ok;

   assign phi2_s    = pad_s[19];
   assign rw_s      = pad_s[18];
   assign csn_s     = pad_s[17];
   assign addr_s    = pad_s[16:8];
   assign data_s    = pad_s[7:0];
   assign sel2      = (SID2_A8 != 0) ? addr_s[8] : addr_s[5];
   assign cs_new    = csn_s ? 2'b00 : (sel2 ? 2'b10 : 2'b01);
   assign unused_ok = ^addr_s[7:6];

   logic [1:0] flt_cnt_q, flt_cnt_d;
   logic       acc_q, acc_d;
   logic       rise, fall;

   always_comb begin
      flt_cnt_d = 2'd0;
      acc_d     = acc_q;
      rise      = 1'b0;
      fall      = 1'b0;
      if (phi2_s != acc_q) begin
         if (flt_cnt_q == FILT_M1) begin
            acc_d = phi2_s;
            rise  = phi2_s;
            fall  = ~phi2_s;
         end else begin
            flt_cnt_d = flt_cnt_q + 2'd1;
         end
      end
   end

   // Accepted level restarts at the pin level so reset never fakes an edge
   always_ff @(posedge clk) begin
      if (!res_n) begin
         flt_cnt_q <= 2'd0;
         acc_q     <= phi2_s;
      end else begin
         flt_cnt_q <= flt_cnt_d;
         acc_q     <= acc_d;
      end
   end

   state_e     state_q;
   logic [3:0] dcnt_q;
   logic       phi2_q;
   logic       rw_q;
   logic [4:0] addr_q;
   logic [7:0] data_q;
   logic [1:0] cs_q;
   logic       oe_q;
   logic       res_q;

   always_ff @(posedge clk) begin
      res_q <= ~res_n;
      if (!res_n) begin
         state_q <= S_LOW;
         dcnt_q  <= 4'd0;
         phi2_q  <= 1'b0;
         rw_q    <= 1'b0;
         addr_q  <= 5'd0;
         data_q  <= 8'd0;
         cs_q    <= 2'b00;
         oe_q    <= 1'b0;
      end else begin
         unique case (state_q)
            S_LOW: begin
               if (rise) begin
                  state_q <= S_SETUP;
                  dcnt_q  <= DLY_M1;
               end
            end
            S_SETUP: begin
               if (fall) begin
                  state_q <= S_LOW;
                  cs_q    <= 2'b00;
               end else if (dcnt_q == 4'd0) begin
                  state_q <= S_HIGH;
                  phi2_q  <= 1'b1;
                  addr_q  <= addr_s[4:0];
                  rw_q    <= rw_s;
                  cs_q    <= cs_new;
                  oe_q    <= rw_s & (|cs_new);
               end else begin
                  dcnt_q <= dcnt_q - 4'd1;
               end
            end
            S_HIGH: begin
               if (fall) begin
                  state_q <= S_LOW;
                  phi2_q  <= 1'b0;
                  oe_q    <= 1'b0;
                  if (!rw_q)
                     data_q <= data_s;
               end
            end
            default: state_q <= S_LOW;
         endcase
      end
   end

   assign bus.bus_o   = {phi2_q, rw_q, addr_q, data_q, res_q};
   assign bus.data_oe = oe_q;

`ifdef SID_BUS_WATCHDOG_EN
   localparam logic [6:0] WD_MAX = 7'(WDOG_CYCLES);

   logic [6:0] wd_q, wd_d;
   logic       idle_q;

   assign wd_d = rise ? 7'd0 :
                 (wd_q == WD_MAX) ? wd_q : wd_q + 7'd1;

   always_ff @(posedge clk) begin
      if (!res_n) begin
         wd_q   <= 7'd0;
         idle_q <= 1'b1;
      end else begin
         wd_q <= wd_d;
         if (rise)
            idle_q <= 1'b0;
         else if (wd_d == WD_MAX)
            idle_q <= 1'b1;
      end
   end

   assign bus.cs       = cs_q & ~{2{idle_q}};
   assign bus.bus_idle = idle_q;
`else
   assign bus.cs       = cs_q;
   assign bus.bus_idle = 1'b0;
`endif

endmodule

// File: tb/tb_sid_bus_frontend.sv
// Bench for sid_bus_frontend: timeline model of the host bus plus
// directed bus cycles with literal expectations.
`timescale 1ns/1ps
module tb_sid_bus_frontend;
  import sid::*;

  localparam int SYNC = 2;
  localparam int FILT = 3;
  localparam int DLY  = 4;
  localparam int A8S  = 0;
  localparam int WDOG = 96;
`ifdef SID_BUS_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;

  sid_bus_frontend_if bus();

  sid_bus_frontend #(
    .SYNC_STAGES(SYNC),
    .PHI2_FILT(FILT),
    .ADDR_DELAY(DLY),
    .SID2_A8(A8S),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk),
    .res_n(res_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       phi2;
    logic       rw;
    logic       csn;
    logic [8:0] a;
    logic [7:0] d;
  } pad_t;

  // Model: pad history indexed by clock edge; the filter is a window
  // of FILT synced samples, the cycle is timestamped from the accepted rise.
  pad_t rec[$];
  int   k = 0;
  int   last_rst = 1000000;
  int   last_rise = -1;
  int   start = 0;
  bit   acc, busy, hi, mdl_ok;
  logic m_phi2 = 0, m_rw = 0, m_res = 1, m_oe = 0, m_idle = 0;
  logic [4:0] m_addr = 0;
  logic [7:0] m_data = 0;
  logic [1:0] m_cs = 0;

  always @(posedge clk) begin : model
    pad_t s;
    bit tog;
    rec.push_back({bus.phi2_pad, bus.r_w_n_pad, bus.cs_n_pad,
                   bus.addr_pad, bus.data_pad});
    s = (k >= SYNC) ? rec[k-SYNC] : '0;
    if (!res_n) begin
      acc = s.phi2; busy = 0; hi = 0;
      m_phi2 = 0; m_rw = 0; m_addr = 0; m_data = 0; m_cs = 0; m_res = 1;
      last_rst = k; last_rise = -1;
      if (k >= SYNC) mdl_ok = 1;
    end else begin
      m_res = 0;
      tog = (k - SYNC - (FILT-1) > last_rst);
      if (tog)
        for (int j = 0; j < FILT; j++)
          if (rec[k-SYNC-j].phi2 == acc) tog = 0;
      if (tog) begin
        acc = ~acc;
        if (acc) begin
          last_rise = k;
          if (!busy) begin busy = 1; start = k; end
        end
      end
      if (busy && !hi) begin
        if (tog && !acc) begin
          busy = 0; m_cs = 0;
        end else if (k == start + DLY) begin
          hi = 1; m_phi2 = 1; m_addr = s.a[4:0]; m_rw = s.rw;
          m_cs = s.csn ? 2'b00 :
                 (((A8S != 0) ? s.a[8] : s.a[5]) ? 2'b10 : 2'b01);
        end
      end else if (hi && tog && !acc) begin
        hi = 0; busy = 0; m_phi2 = 0;
        if (!m_rw) m_data = s.d;
      end
    end
    m_oe   = m_phi2 & m_rw & (|m_cs);
    m_idle = WD_ON && (last_rise < 0 || k - last_rise >= WDOG);
    k++;
  end

  always @(negedge clk) begin : compare
    if (mdl_ok) begin
      check("bus_o", bus.bus_o, {m_phi2, m_rw, m_addr, m_data, m_res});
      check("cs", 16'(bus.cs), 16'(m_idle ? 2'b00 : m_cs));
      check("data_oe", 16'(bus.data_oe), 16'(m_oe));
      check("bus_idle", 16'(bus.bus_idle), 16'(m_idle));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_cycle(input logic [8:0] a, input logic rw,
                           input logic csn, input logic [7:0] d,
                           output bit seen);
    seen = 0;
    bus.addr_pad = a; bus.r_w_n_pad = rw; bus.cs_n_pad = csn;
    bus.phi2_pad = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) bus.data_pad = d;
      @(negedge clk);
      seen |= bus.bus_o.phi2;
    end
    bus.phi2_pad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen |= bus.bus_o.phi2;
    end
  endtask

  initial begin : stim
    bit seen;
    int n;
    bus.phi2_pad = 0; bus.r_w_n_pad = 1; bus.cs_n_pad = 1;
    bus.addr_pad = 9'h000; bus.data_pad = 8'h00;
    tick(6);
    check("rst_bus", bus.bus_o, 16'h0001);
    check("rst_cs", 16'(bus.cs), 16'h0);
    check("rst_oe", 16'(bus.data_oe), 16'h0);
    check("rst_idle", 16'(bus.bus_idle), 16'(WD_ON));
    res_n = 1'b1;
    tick(1);
    check("res_release", 16'(bus.bus_o.res), 16'h0);
    tick(12);

    bus_cycle(9'h018, 1'b0, 1'b0, 8'h0F, seen);
    check("wr_phi2_seen", 16'(seen), 16'h1);
    check("wr_addr", 16'(bus.bus_o.addr), 16'h18);
    check("wr_cs", 16'(bus.cs), 16'h1);
    check("wr_rw", 16'(bus.bus_o.r_w_n), 16'h0);
    check("wr_data", 16'(bus.bus_o.data), 16'h0F);
    check("wr_oe", 16'(bus.data_oe), 16'h0);

    bus.addr_pad = 9'h03B; bus.r_w_n_pad = 1; bus.cs_n_pad = 0;
    bus.phi2_pad = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (bus.bus_o.phi2) break;
    end
    check("rd_latency", 16'(n), 16'd9);
    check("rd_oe_high", 16'(bus.data_oe), 16'h1);
    tick(3);
    bus.phi2_pad = 1'b0;
    tick(12);
    check("rd_cs", 16'(bus.cs), 16'h2);
    check("rd_addr", 16'(bus.bus_o.addr), 16'h1B);
    check("rd_rw", 16'(bus.bus_o.r_w_n), 16'h1);
    check("rd_data_kept", 16'(bus.bus_o.data), 16'h0F);

    bus.phi2_pad = 1'b1; tick(2);
    bus.phi2_pad = 1'b0; tick(12);
    check("glitch_bus", bus.bus_o, {1'b0, 1'b1, 5'h1B, 8'h0F, 1'b0});
    check("glitch_cs", 16'(bus.cs), 16'h2);

    bus.addr_pad = 9'h018; bus.r_w_n_pad = 0; bus.cs_n_pad = 0;
    bus.phi2_pad = 1'b1; tick(3);
    bus.phi2_pad = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen |= bus.bus_o.phi2;
    end
    check("short_phi2", 16'(seen), 16'h0);
    check("short_cs", 16'(bus.cs), 16'h0);
    check("short_addr", 16'(bus.bus_o.addr), 16'h1B);
    check("short_data", 16'(bus.bus_o.data), 16'h0F);

    bus_cycle(9'h005, 1'b1, 1'b1, 8'h77, seen);
    check("csn_phi2_seen", 16'(seen), 16'h1);
    check("csn_cs", 16'(bus.cs), 16'h0);
    check("csn_addr", 16'(bus.bus_o.addr), 16'h05);
    check("csn_data", 16'(bus.bus_o.data), 16'h0F);

    bus.addr_pad = 9'h018; bus.r_w_n_pad = 0; bus.cs_n_pad = 0;
    bus.data_pad = 8'h33;
    bus.phi2_pad = 1'b1; tick(11);
    check("mid_phi2", 16'(bus.bus_o.phi2), 16'h1);
    res_n = 1'b0; tick(1); res_n = 1'b1;
    check("mid_rst_bus", bus.bus_o, 16'h0001);
    check("mid_rst_cs", 16'(bus.cs), 16'h0);
    check("mid_rst_oe", 16'(bus.data_oe), 16'h0);
    tick(1);
    bus.phi2_pad = 1'b0; tick(12);
    check("mid_after_bus", bus.bus_o, 16'h0000);

    bus_cycle(9'h120, 1'b0, 1'b0, 8'h5A, seen);
    check("post_addr", 16'(bus.bus_o.addr), 16'h00);
    check("post_cs", 16'(bus.cs), 16'h2);
    check("post_data", 16'(bus.bus_o.data), 16'h5A);

    tick(100);
    check("wd_idle", 16'(bus.bus_idle), 16'(WD_ON));
    bus_cycle(9'h018, 1'b1, 1'b0, 8'h00, seen);
    check("wd_resume_idle", 16'(bus.bus_idle), 16'h0);
    check("wd_resume_cs", 16'(bus.cs), 16'h1);
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
